custom_wptr_full: RTL

Write-side pointer and full-flag generator for the asynchronous FIFO, running entirely in the write clock domain. It is the counterpart of the read-side pointer/empty block. It advances a binary write pointer on accepted writes and exports it as Gray code for synchronization into the read domain. From the read Gray pointer, already synchronized into the write domain, it derives registered full, almost-full, fill-level and sticky-overflow status.

---
 rtl/custom_wptr_full.sv | 102 ++++++++++
 1 files changed

// File: rtl/custom_wptr_full.sv
// Write-side pointer and full-flag generator for an asynchronous FIFO.
// Runs in the write clock domain only. It keeps a binary write pointer and a
// Gray copy for the read domain. From the synchronized read Gray pointer it
// produces registered full, almost-full, fill level and sticky overflow.
//
// Handshake: a write is accepted on an edge when wen is high and the
// registered fifo_full is low. wen acts as valid and ~fifo_full as ready.
// A write offered while full is dropped: the pointer holds, memory is not
// written, and fifo_overflow is set.
module custom_wptr_full #(
  parameter int ADDRSIZE = 4,
  parameter int AF_SLACK = 1
) (
  input  logic                wclk_i,
  input  logic                wrst_i,
  input  logic                wen,
  input  logic [ADDRSIZE:0]   rptr_sync2_wrclk,
  input  logic                ovf_clr,
  output logic [ADDRSIZE-1:0] wr_addr,
  output logic [ADDRSIZE:0]   wptr_g,
  output logic                fifo_full,
  output logic                fifo_almost_full,
  output logic [ADDRSIZE:0]   wr_level,
  output logic                fifo_overflow
);

  localparam int A = ADDRSIZE;
  localparam logic [A:0] FULL_LEVEL = (A+1)'(2 ** A);
  localparam logic [A:0] AF_THRESH  = (A+1)'((2 ** A) - AF_SLACK);

  logic [A:0] wbin_q, wbin_d;
  logic [A:0] wgray_q, wgray_d;
  logic [A:0] level_q, level_d;
  logic [A:0] rbin;
  logic [A:0] rgray_shift;
  logic       full_q, full_d;
  logic       af_q, af_d;
  logic       ovf_q, ovf_d;
  logic       wr_accept;

  // Gray-to-binary of the read pointer: bit i is the XOR of all bits from
  // the MSB down to bit i.
  always_comb begin
    rbin        = '0;
    rgray_shift = '0;
    for (int i = 0; i <= A; i++) begin
      rgray_shift = rptr_sync2_wrclk >> i;
      rbin[i]     = ^rgray_shift;
    end
  end

  // Next pointer, Gray code, level and flag values for the coming edge.
  always_comb begin
    wr_accept = wen & ~full_q;
    wbin_d    = wbin_q + {{A{1'b0}}, wr_accept};
    wgray_d   = (wbin_d >> 1) ^ wbin_d;
    // The full pattern is the read Gray pointer with its two MSBs inverted.
    // That is the write pointer sitting exactly one lap ahead of the reader.
    full_d    = (wgray_d == {~rptr_sync2_wrclk[A:A-1], rptr_sync2_wrclk[A-2:0]});
    level_d   = wbin_d - rbin;
    af_d      = (level_d >= AF_THRESH);
    // Set has priority over clear so that a dropped write is never missed.
    if (wen && full_q)
      ovf_d = 1'b1;
    else if (ovf_clr)
      ovf_d = 1'b0;
    else
      ovf_d = ovf_q;
  end

  // State and flag registers with asynchronous reset.
  always_ff @(posedge wclk_i or posedge wrst_i) begin
    if (wrst_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_addr          = wbin_q[A-1:0];
  assign wptr_g           = wgray_q;
  assign fifo_full        = full_q;
  assign fifo_almost_full = af_q;
  assign wr_level         = level_q;
  assign fifo_overflow    = ovf_q;

  // The Gray-compare full detection must agree with the binary level.
  a_full_matches_level: assert property (
    @(posedge wclk_i) disable iff (wrst_i) full_d == (level_d == FULL_LEVEL)
  );

endmodule
